persp_viewport: RTL and testbench
=================================

Name: persp_viewport

Overview:
- Clip-space stage directly downstream of the vertex transform.
- Takes clip coordinates (x, y, z, w) for three triangle vertices, signed 16.16 fixed point, and performs the perspective divide using one shared sequential divider.
- Maps the resulting NDC values to integer screen pixels and a 16.16 depth value.
- Culls any triangle with a vertex at or behind the eye plane (w <= 0); results feed the rasterizer setup.

Parameters:
- WIDTH, 640, screen width in pixels; must be even, at most 32768.
- HEIGHT, 480, screen height in pixels; must be even, at most 32768.
- FRAC_BITS, 16, fractional bits of all fixed-point values; fixed at 16.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- x_in[2:0]  in  32 each  clip x per vertex, signed 16.16.
- y_in[2:0]  in  32 each  clip y per vertex, signed 16.16.
- z_in[2:0]  in  32 each  clip z per vertex, signed 16.16.
- w_in[2:0]  in  32 each  clip w per vertex, signed 16.16.
- ready  in  1  start request; sampled only in IDLE.
- sx_out[2:0]  out  16 each  screen x, unsigned pixel index.
- sy_out[2:0]  out  16 each  screen y, unsigned pixel index.
- sz_out[2:0]  out  32 each  depth, unsigned 16.16 in [0, 1.0].
- culled  out  1  triangle rejected; valid while done is high and held afterwards.
- busy  out  1  high from the capture edge until done rises.
- done  out  1  one-cycle pulse; results valid.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - All outputs go to 0 (sx/sy/sz, culled, busy, done).
  - Divider is cleared.
  - Reset mid-operation aborts the triangle; no done is produced.
- FSM states: IDLE, CHECK, DIV, VIEWPORT, DONE.
- IDLE:
  - When ready=1 at an edge (E0), all 12 inputs are latched, busy is set, next state is CHECK.
  - ready while busy=1 is ignored; the inputs are not re-latched.
- CHECK (E1): if any latched w <= 0 (signed compare), go to DONE with culled=1 and all sx/sy/sz=0. Otherwise culled=0 and go to DIV.
- DIV:
  - Nine divides run in fixed order v0x, v0y, v0z, v1x, … v2z.
  - Each divide is one load cycle plus 48 iteration cycles, so 49 cycles per divide.
  - Dividend is |n|<<16 (48-bit); divisor is w (positive).
  - Restoring division produces 1 quotient bit per cycle.
  - The result sign is applied after iteration.
  - Magnitudes above 0x7FFFFFFF saturate to +/-0x7FFFFFFF.
  - Results are stored as ndc_x/y/z per vertex.
- VIEWPORT: one cycle per vertex, three cycles total. Products use 64-bit signed arithmetic:
  - sx = ((ndc_x + 0x10000) * (WIDTH/2)) >>> 16, clamped to [0, WIDTH-1].
  - sy = ((0x10000 - ndc_y) * (HEIGHT/2)) >>> 16, clamped to [0, HEIGHT-1]; screen y points down.
  - sz = (ndc_z + 0x10000) >>> 1, clamped to [0, 0x10000].
- DONE: done=1 for exactly one cycle and busy=0 in the same cycle, then return to IDLE.
- Latency:
  - Culled triangle: done high after edge E2.
  - Accepted triangle: done high after edge E2 + 9*49 + 3 = E446.
  - Latency is fixed and independent of data.
- Output stability:
  - Output registers update only on the VIEWPORT/CHECK writes of a new triangle.
  - They hold their values otherwise, including while the next triangle is being processed, until they are overwritten.
- Back-to-back: ready high in the DONE cycle is ignored; ready high in the following IDLE cycle is accepted.

Decomposition:
- Package pv_pkg:
  - FRAC_BITS = 16 and FP_ONE = 32'h0001_0000.
  - DIV_ITERS = 48.
  - State enum typedef {IDLE, CHECK, DIV, VIEWPORT, DONE}.
  - Typedef fx16_t = logic signed [31:0].
- Sub-module fx_div_seq:
  - Sequential signed 16.16 divider.
  - Ports: clock, reset, start, num, den, quo, sat, done.
  - Reused later by lighting normalisation.

Test Plan:
- Single vertex case: vertex (0, 0, 0, w=1.0) on all three vertices with WIDTH=640, HEIGHT=480 -> sx=320, sy=240, sz=0x8000, culled=0, done exactly 446 edges after capture.
- Edge of screen: x=2.0, y=-2.0, z=2.0, w=2.0 (ndc 1, -1, 1) -> sx=639 (clamped from 640), sy=479 (clamped), sz=0x10000.
- Cull: w_in[1]=0 and the other w values 1.0 -> culled=1, all outputs 0, done after E2, busy low in the done cycle.
- Saturation: x=0x7FFF0000, w=0x00000100 -> quotient saturates to 0x7FFFFFFF, sx=639. Also x=-0x7FFF0000 -> sx=0.
- Handshake: ready pulsed again at cycle 100 with different inputs -> ignored, results match the first triangle. A second ready one cycle after done -> accepted.
- Reset mid-DIV at cycle 200 -> the next cycle shows busy=0 and done=0 with outputs at 0; no done pulse follows; a new ready then completes normally.

Source files
------------

// File: rtl/pv_pkg.sv
// Shared constants and types for the clip-space perspective/viewport stage
// and its sequential fixed-point divider.
package pv_pkg;
    localparam int          FRAC_BITS = 16;
    localparam logic [31:0] FP_ONE    = 32'h0001_0000;
    localparam int          DIV_ITERS = 48;

    typedef enum logic [2:0] {IDLE, CHECK, DIV, VIEWPORT, DONE} pvState_t;

    typedef logic signed [31:0] fx16_t;
endpackage

// File: rtl/fx_div_seq.sv
// Sequential signed 16.16 divider: one load cycle, then one restoring quotient
// bit per cycle; the sign is applied to the saturated magnitude afterwards.
module fx_div_seq
    import pv_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  start,
    input  fx16_t num,
    input  fx16_t den,
    output fx16_t quo,
    output logic  sat,
    output logic  done
);
    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

    logic [5:0]  cnt_q, cnt_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic        neg_q, neg_d;
    logic [31:0] den_q, den_d;
    logic [31:0] rem_q, rem_d;
    logic [47:0] dvd_q, dvd_d;

    logic [31:0] numMag;
    logic [31:0] denMag;
    logic [32:0] remShift;
    logic [31:0] remSub;
    logic        fits;
    logic [30:0] quoMag;

    // The dividend register doubles as the quotient register: each iteration
    // shifts a dividend bit out of the top and a quotient bit in at the bottom.
    always_comb begin
        numMag   = num[31] ? 32'(-num) : 32'(num);
        denMag   = den[31] ? 32'(-den) : 32'(den);
        remShift = {rem_q, dvd_q[47]};
        remSub   = remShift[31:0] - den_q;
        fits     = (remShift >= {1'b0, den_q});

        cnt_d     = cnt_q;
        running_d = running_q;
        done_d    = 1'b0;
        neg_d     = neg_q;
        den_d     = den_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;

        if (start) begin
            cnt_d     = '0;
            running_d = 1'b1;
            neg_d     = num[31] ^ den[31];
            den_d     = denMag;
            rem_d     = '0;
            dvd_d     = {numMag, 16'h0000};
        end else if (running_q) begin
            rem_d = fits ? remSub : remShift[31:0];
            dvd_d = {dvd_q[46:0], fits};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST_ITER) begin
                running_d = 1'b0;
                done_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            neg_q     <= 1'b0;
            den_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
            neg_q     <= neg_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
        end
    end

    always_comb begin
        sat    = |dvd_q[47:31];
        quoMag = sat ? '1 : dvd_q[30:0];
        quo    = neg_q ? -fx16_t'({1'b0, quoMag}) : fx16_t'({1'b0, quoMag});
        done   = done_q;
    end
endmodule

// File: rtl/persp_viewport.sv
// Perspective divide and viewport mapping for one triangle: culls on w <= 0,
// runs nine shared divides, then maps NDC to pixels and 16.16 depth.
module persp_viewport
    import pv_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int FRAC_BITS = 16
)(
    input  logic        clock,
    input  logic        reset,
    input  fx16_t       x_in [3],
    input  fx16_t       y_in [3],
    input  fx16_t       z_in [3],
    input  fx16_t       w_in [3],
    input  logic        ready,
    output logic [15:0] sx_out [3],
    output logic [15:0] sy_out [3],
    output logic [31:0] sz_out [3],
    output logic        culled,
    output logic        busy,
    output logic        done
);
    localparam logic signed [63:0] ONE64 = 64'(FP_ONE);

    function automatic logic [15:0] toPixel(input fx16_t ndc, input logic flip,
                                            input int half, input int limit);
        logic signed [63:0] base;
        logic signed [63:0] scaled;
        base   = flip ? (ONE64 - 64'(ndc)) : (64'(ndc) + ONE64);
        scaled = (base * 64'(half)) >>> FRAC_BITS;
        if (scaled < 0)
            return '0;
        else if (scaled > 64'(limit))
            return 16'(limit);
        else
            return scaled[15:0];
    endfunction

    function automatic logic [31:0] toDepth(input fx16_t ndc);
        logic signed [63:0] halved;
        halved = (64'(ndc) + ONE64) >>> 1;
        if (halved < 0)
            return '0;
        else if (halved > ONE64)
            return FP_ONE;
        else
            return halved[31:0];
    endfunction

    pvState_t    state_q, state_d;
    fx16_t       xLat_q [3], xLat_d [3];
    fx16_t       yLat_q [3], yLat_d [3];
    fx16_t       zLat_q [3], zLat_d [3];
    fx16_t       wLat_q [3], wLat_d [3];
    fx16_t       ndc_q [9], ndc_d [9];
    logic [15:0] sx_q [3], sx_d [3];
    logic [15:0] sy_q [3], sy_d [3];
    logic [31:0] sz_q [3], sz_d [3];
    logic        culled_q, culled_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [5:0]  cyc_q, cyc_d;
    logic [3:0]  divIdx_q, divIdx_d;
    logic [3:0]  storeIdx_q, storeIdx_d;
    logic [1:0]  vpIdx_q, vpIdx_d;

    fx16_t       numSel [9];
    fx16_t       denSel [9];
    logic        anyCull;
    logic [3:0]  vBase;
    logic        divStart;
    fx16_t       divNum, divDen, divQuo;
    logic        divDone;
    logic        unusedDivSat;

    fx_div_seq u_div (
        .clock (clock),
        .reset (reset),
        .start (divStart),
        .num   (divNum),
        .den   (divDen),
        .quo   (divQuo),
        .sat   (unusedDivSat),
        .done  (divDone)
    );

    // Divides are issued in v0x, v0y, v0z, v1x ... order, so flatten the
    // latched vertex data into that sequence.
    always_comb begin
        anyCull = 1'b0;
        for (int v = 0; v < 3; v++) begin
            numSel[3*v]     = xLat_q[v];
            numSel[3*v + 1] = yLat_q[v];
            numSel[3*v + 2] = zLat_q[v];
            denSel[3*v]     = wLat_q[v];
            denSel[3*v + 1] = wLat_q[v];
            denSel[3*v + 2] = wLat_q[v];
            if (wLat_q[v] <= 0)
                anyCull = 1'b1;
        end
        divNum = numSel[divIdx_q];
        divDen = denSel[divIdx_q];
        case (vpIdx_q)
            2'd0:    vBase = 4'd0;
            2'd1:    vBase = 4'd3;
            default: vBase = 4'd6;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        xLat_d     = xLat_q;
        yLat_d     = yLat_q;
        zLat_d     = zLat_q;
        wLat_d     = wLat_q;
        ndc_d      = ndc_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        sz_d       = sz_q;
        culled_d   = culled_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cyc_d      = cyc_q;
        divIdx_d   = divIdx_q;
        storeIdx_d = storeIdx_q;
        vpIdx_d    = vpIdx_q;
        divStart   = 1'b0;

        // A finished divide is collected on the cycle after its last iteration,
        // which is also the load cycle of the next one (or the first viewport cycle).
        if (divDone) begin
            ndc_d[storeIdx_q] = divQuo;
            storeIdx_d        = storeIdx_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (ready) begin
                    xLat_d  = x_in;
                    yLat_d  = y_in;
                    zLat_d  = z_in;
                    wLat_d  = w_in;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                culled_d   = anyCull;
                cyc_d      = '0;
                divIdx_d   = '0;
                storeIdx_d = '0;
                if (anyCull) begin
                    sx_d    = '{default: '0};
                    sy_d    = '{default: '0};
                    sz_d    = '{default: '0};
                    state_d = DONE;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                divStart = (cyc_q == 6'd0);
                cyc_d    = cyc_q + 6'd1;
                if (cyc_q == 6'(DIV_ITERS)) begin
                    cyc_d = '0;
                    if (divIdx_q == 4'd8) begin
                        vpIdx_d = '0;
                        state_d = VIEWPORT;
                    end else begin
                        divIdx_d = divIdx_q + 4'd1;
                    end
                end
            end
            VIEWPORT: begin
                sx_d[vpIdx_q] = toPixel(ndc_q[vBase], 1'b0, WIDTH / 2, WIDTH - 1);
                sy_d[vpIdx_q] = toPixel(ndc_q[vBase + 4'd1], 1'b1, HEIGHT / 2, HEIGHT - 1);
                sz_d[vpIdx_q] = toDepth(ndc_q[vBase + 4'd2]);
                vpIdx_d       = vpIdx_q + 2'd1;
                if (vpIdx_q == 2'd2)
                    state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            xLat_q     <= '{default: '0};
            yLat_q     <= '{default: '0};
            zLat_q     <= '{default: '0};
            wLat_q     <= '{default: '0};
            ndc_q      <= '{default: '0};
            sx_q       <= '{default: '0};
            sy_q       <= '{default: '0};
            sz_q       <= '{default: '0};
            culled_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cyc_q      <= '0;
            divIdx_q   <= '0;
            storeIdx_q <= '0;
            vpIdx_q    <= '0;
        end else begin
            state_q    <= state_d;
            xLat_q     <= xLat_d;
            yLat_q     <= yLat_d;
            zLat_q     <= zLat_d;
            wLat_q     <= wLat_d;
            ndc_q      <= ndc_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            sz_q       <= sz_d;
            culled_q   <= culled_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cyc_q      <= cyc_d;
            divIdx_q   <= divIdx_d;
            storeIdx_q <= storeIdx_d;
            vpIdx_q    <= vpIdx_d;
        end
    end

    assign sx_out = sx_q;
    assign sy_out = sy_q;
    assign sz_out = sz_q;
    assign culled = culled_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_persp_viewport.sv
// Scoreboard bench for persp_viewport: a plain-arithmetic reference model
// predicts each triangle's results and done time; a monitor checks on done.
module tb_persp_viewport;
    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               ready = 1'b0;
    logic signed [31:0] x_in [3];
    logic signed [31:0] y_in [3];
    logic signed [31:0] z_in [3];
    logic signed [31:0] w_in [3];
    logic [15:0]        sx_out [3];
    logic [15:0]        sy_out [3];
    logic [31:0]        sz_out [3];
    logic               culled;
    logic               busy;
    logic               done;

    persp_viewport #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FRAC_BITS(16)) dut (
        .clock  (clock),
        .reset  (reset),
        .x_in   (x_in),
        .y_in   (y_in),
        .z_in   (z_in),
        .w_in   (w_in),
        .ready  (ready),
        .sx_out (sx_out),
        .sy_out (sy_out),
        .sz_out (sz_out),
        .culled (culled),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    int cycleCount = 0;
    always @(posedge clock) cycleCount <= cycleCount + 1;

    typedef struct {
        int x[3];
        int y[3];
        int z[3];
        int w[3];
    } tri_t;

    typedef struct {
        longint sx[3];
        longint sy[3];
        longint sz[3];
        bit     culled;
        int     doneCycle;
    } expect_t;

    expect_t scoreboard[$];
    int testCount = 0;
    int failCount = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: exact integer quotient of |n|*2^16 / w, saturated, signed.
    function automatic longint refNdc(int n, int w);
        longint mag;
        longint q;
        mag = (n < 0) ? -longint'(n) : longint'(n);
        q   = (mag * 65536) / longint'(w);
        if (q > 64'h7FFF_FFFF) q = 64'h7FFF_FFFF;
        return (n < 0) ? -q : q;
    endfunction

    function automatic longint refPixel(longint ndc, bit flip, longint half, longint limit);
        longint s;
        s = ((flip ? (65536 - ndc) : (ndc + 65536)) * half) >>> 16;
        if (s < 0) return 0;
        if (s > limit) return limit;
        return s;
    endfunction

    function automatic longint refDepth(longint ndc);
        longint s;
        s = (ndc + 65536) >>> 1;
        if (s < 0) return 0;
        if (s > 65536) return 65536;
        return s;
    endfunction

    function automatic expect_t refModel(tri_t t);
        expect_t e;
        bit cull = 1'b0;
        for (int v = 0; v < 3; v++)
            if (t.w[v] <= 0) cull = 1'b1;
        e.culled    = cull;
        e.doneCycle = 0;
        for (int v = 0; v < 3; v++) begin
            if (cull) begin
                e.sx[v] = 0;
                e.sy[v] = 0;
                e.sz[v] = 0;
            end else begin
                e.sx[v] = refPixel(refNdc(t.x[v], t.w[v]), 1'b0, WIDTH / 2, WIDTH - 1);
                e.sy[v] = refPixel(refNdc(t.y[v], t.w[v]), 1'b1, HEIGHT / 2, HEIGHT - 1);
                e.sz[v] = refDepth(refNdc(t.z[v], t.w[v]));
            end
        end
        return e;
    endfunction

    function automatic tri_t mkUniform(int x, int y, int z, int w);
        tri_t t;
        for (int v = 0; v < 3; v++) begin
            t.x[v] = x;
            t.y[v] = y;
            t.z[v] = z;
            t.w[v] = w;
        end
        return t;
    endfunction

    function automatic tri_t randomTri(bit allowCull);
        tri_t t;
        int   kind;
        int   span;
        for (int v = 0; v < 3; v++) begin
            kind = int'($urandom_range(0, 9));
            if (allowCull && kind == 0)
                t.w[v] = -int'($urandom_range(0, 32'h2_0000));
            else
                t.w[v] = int'($urandom_range(32'h100, 32'h8_0000));
            span   = (t.w[v] > 0) ? t.w[v] : 32'h1_0000;
            t.x[v] = int'($urandom_range(0, 4 * span)) - 2 * span;
            t.y[v] = int'($urandom_range(0, 4 * span)) - 2 * span;
            t.z[v] = int'($urandom_range(0, 4 * span)) - 2 * span;
            if (kind == 9) begin
                t.x[v] = int'($urandom);
                t.y[v] = int'($urandom);
            end
        end
        return t;
    endfunction

    task automatic issueTriangle(input tri_t t);
        expect_t e;
        @(negedge clock);
        for (int v = 0; v < 3; v++) begin
            x_in[v] = t.x[v];
            y_in[v] = t.y[v];
            z_in[v] = t.z[v];
            w_in[v] = t.w[v];
        end
        ready = 1'b1;
        e = refModel(t);
        @(negedge clock);
        ready = 1'b0;
        e.doneCycle = cycleCount + (e.culled ? 2 : 446);
        scoreboard.push_back(e);
    endtask

    task automatic waitDone(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL doneTimeout: no done within %0d cycles (done=%0d)", budget, done);
            scoreboard.delete();
        end
    endtask

    task automatic applyStimulus(input tri_t t, input int pokeAt);
        issueTriangle(t);
        if (pokeAt > 0) begin
            repeat (pokeAt - 1) @(negedge clock);
            checkOutput("busyBeforePoke", busy, 1);
            for (int v = 0; v < 3; v++) begin
                x_in[v] = int'($urandom_range(0, 32'h4_0000)) - 32'sh2_0000;
                y_in[v] = int'($urandom_range(0, 32'h4_0000)) - 32'sh2_0000;
                z_in[v] = int'($urandom_range(0, 32'h4_0000)) - 32'sh2_0000;
                w_in[v] = 32'sh1_0000;
            end
            ready = 1'b1;
            @(negedge clock);
            ready = 1'b0;
        end
        waitDone(600);
    endtask

    task automatic resetMidDiv(input tri_t t);
        issueTriangle(t);
        repeat (199) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstCulled", culled, 0);
        for (int v = 0; v < 3; v++) begin
            checkOutput($sformatf("rstSx[%0d]", v), sx_out[v], 0);
            checkOutput($sformatf("rstSy[%0d]", v), sy_out[v], 0);
            checkOutput($sformatf("rstSz[%0d]", v), sz_out[v], 0);
        end
        reset = 1'b0;
        scoreboard.delete();
        repeat (500) @(negedge clock);
    endtask

    // Monitor: every done pulse must match the oldest outstanding prediction.
    initial begin
        expect_t e;
        forever begin
            @(negedge clock);
            if (done) begin
                if (scoreboard.size() == 0) begin
                    testCount++;
                    failCount++;
                    $display("[TB] FAIL unexpectedDone: done=%0d with no triangle pending at cycle %0d",
                             done, cycleCount);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("culled", culled, e.culled);
                    checkOutput("doneCycle", cycleCount, e.doneCycle);
                    checkOutput("busyAtDone", busy, 0);
                    for (int v = 0; v < 3; v++) begin
                        checkOutput($sformatf("sx[%0d]", v), sx_out[v], e.sx[v]);
                        checkOutput($sformatf("sy[%0d]", v), sy_out[v], e.sy[v]);
                        checkOutput($sformatf("sz[%0d]", v), sz_out[v], e.sz[v]);
                    end
                end
            end
        end
    end

    initial begin
        tri_t t;
        for (int v = 0; v < 3; v++) begin
            x_in[v] = '0;
            y_in[v] = '0;
            z_in[v] = '0;
            w_in[v] = '0;
        end
        repeat (3) @(negedge clock);
        checkOutput("initBusy", busy, 0);
        checkOutput("initDone", done, 0);
        checkOutput("initCulled", culled, 0);
        checkOutput("initSx0", sx_out[0], 0);
        checkOutput("initSy2", sy_out[2], 0);
        checkOutput("initSz1", sz_out[1], 0);
        reset = 1'b0;

        applyStimulus(mkUniform(0, 0, 0, 32'sh1_0000), 0);
        applyStimulus(mkUniform(32'sh2_0000, -32'sh2_0000, 32'sh2_0000, 32'sh2_0000), 0);

        t = mkUniform(0, 0, 0, 32'sh1_0000);
        t.w[1] = 0;
        applyStimulus(t, 0);

        applyStimulus(mkUniform(32'sh7FFF_0000, 0, 0, 32'sh100), 0);
        applyStimulus(mkUniform(-32'sh7FFF_0000, 0, 0, 32'sh100), 0);

        applyStimulus(randomTri(1'b0), 100);
        applyStimulus(mkUniform(32'sh2_0000, -32'sh2_0000, 32'sh2_0000, 32'sh2_0000), 0);

        resetMidDiv(randomTri(1'b0));
        applyStimulus(mkUniform(0, 0, 0, 32'sh1_0000), 0);

        for (int i = 0; i < 20; i++)
            applyStimulus(randomTri(1'b1), 0);

        repeat (5) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
